// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - raw key inputs and conditioned key outputs
interface key_conditioner_if;
   logic [2:0] key_n;
   logic [2:0] pressed;
   logic [2:0] press_pulse;
   logic [2:0] release_pulse;
   logic [2:0] long_pulse;

   // Drives the raw keys and observes the conditioned levels and pulses.
   modport master (
      output key_n,
      input  pressed,
      input  press_pulse,
      input  release_pulse,
      input  long_pulse
   );

   // The conditioner itself.
   modport slave (
      input  key_n,
      output pressed,
      output press_pulse,
      output release_pulse,
      output long_pulse
   );
endinterface

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - key synchroniser, debouncer and press/release/long-press pulse generator
module key_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned LONG_CYCLES     = 50000000
) (
   input  logic             clk,
   input  logic             rst_n,
   key_conditioner_if.slave kif
);

   localparam logic [19:0] DEBOUNCE_LAST = 20'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0] LONG_LAST     = 32'(LONG_CYCLES - 1);

   // Two-stage synchroniser; keys idle high, so both stages reset to released.
   logic [2:0]  sync1;
   logic [2:0]  sync2;

   // Accepted key level (active low, like the raw key) and its debounce counters.
   logic [2:0]  stable;
   logic [2:0]  stable_nx;
   logic [19:0] db_cnt    [3];
   logic [19:0] db_cnt_nx [3];

   // Hold timing for the long-press pulse; long_done keeps it to one per press.
   logic [31:0] hold_cnt    [3];
   logic [31:0] hold_cnt_nx [3];
   logic [2:0]  long_done;
   logic [2:0]  long_done_nx;

   // Registered outputs and their next values.
   logic [2:0]  pressed_q;
   logic [2:0]  press_q;
   logic [2:0]  release_q;
   logic [2:0]  long_q;
   logic [2:0]  press_nx;
   logic [2:0]  release_nx;
   logic [2:0]  long_nx;

   // Per-key next-state: debounce qualification, edge pulses and long-press timing.
   always_comb begin
      stable_nx    = stable;
      long_done_nx = long_done;
      press_nx     = '0;
      release_nx   = '0;
      long_nx      = '0;
      for (int i = 0; i < 3; i++) begin
         db_cnt_nx[i]   = db_cnt[i];
         hold_cnt_nx[i] = hold_cnt[i];

         // Any sample agreeing with the accepted level restarts qualification.
         if (sync2[i] == stable[i]) begin
            db_cnt_nx[i] = '0;
         end else if (db_cnt[i] == DEBOUNCE_LAST) begin
            stable_nx[i]  = sync2[i];
            db_cnt_nx[i]  = '0;
            press_nx[i]   = stable[i];
            release_nx[i] = ~stable[i];
         end else begin
            db_cnt_nx[i] = db_cnt[i] + 20'd1;
         end

         // A release on the expiry edge takes precedence, so no long pulse then.
         if (press_nx[i] || release_nx[i]) begin
            hold_cnt_nx[i]  = '0;
            long_done_nx[i] = 1'b0;
         end else if (pressed_q[i] && !long_done[i]) begin
            if (hold_cnt[i] == LONG_LAST) begin
               long_nx[i]      = 1'b1;
               long_done_nx[i] = 1'b1;
            end else begin
               hold_cnt_nx[i] = hold_cnt[i] + 32'd1;
            end
         end
      end
   end

   // State and output registers; reset discards any qualification in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1     <= '1;
         sync2     <= '1;
         stable    <= '1;
         long_done <= '0;
         pressed_q <= '0;
         press_q   <= '0;
         release_q <= '0;
         long_q    <= '0;
         for (int i = 0; i < 3; i++) begin
            db_cnt[i]   <= '0;
            hold_cnt[i] <= '0;
         end
      end else begin
         sync1     <= kif.key_n;
         sync2     <= sync1;
         stable    <= stable_nx;
         long_done <= long_done_nx;
         pressed_q <= ~stable_nx;
         press_q   <= press_nx;
         release_q <= release_nx;
         long_q    <= long_nx;
         for (int i = 0; i < 3; i++) begin
            db_cnt[i]   <= db_cnt_nx[i];
            hold_cnt[i] <= hold_cnt_nx[i];
         end
      end
   end

   assign kif.pressed       = pressed_q;
   assign kif.press_pulse   = press_q;
   assign kif.release_pulse = release_q;
   assign kif.long_pulse    = long_q;

endmodule
